// File: rtl/march_bist_ctrl_if.sv
// march_bist_ctrl_if
// Bundles the BIST controller's RAM-side bus and its test handshake/result
// signals so the controller and whatever sits around it share one port.
//
// Signals
//   start      begin a test run (driven by the integrator / bench)
//   ram_q      RAM read data returned to the controller
//   ram_addr   RAM address driven by the controller
//   ram_data   RAM write data driven by the controller
//   ram_we     RAM write enable driven by the controller
//   busy       test in progress
//   done       test finished, held until the next accepted start
//   pass       valid while done: 1 = no mismatch seen
//   fail_elem  march element (1..5) of the first mismatch
//   fail_addr  address of the first mismatch
//   fail_exp   expected word at the first mismatch
//   fail_act   observed word at the first mismatch
//
// Modports
//   master  the BIST controller side
//   slave   the RAM / integrator side
interface march_bist_ctrl_if #(
    parameter int addr_width = 6,
    parameter int data_width = 8
);
    logic                  start;
    logic [data_width-1:0] ram_q;
    logic [addr_width-1:0] ram_addr;
    logic [data_width-1:0] ram_data;
    logic                  ram_we;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [2:0]            fail_elem;
    logic [addr_width-1:0] fail_addr;
    logic [data_width-1:0] fail_exp;
    logic [data_width-1:0] fail_act;

    modport master (
        input  start, ram_q,
        output ram_addr, ram_data, ram_we,
        output busy, done, pass, fail_elem, fail_addr, fail_exp, fail_act
    );

    modport slave (
        output start, ram_q,
        input  ram_addr, ram_data, ram_we,
        input  busy, done, pass, fail_elem, fail_addr, fail_exp, fail_act
    );
endinterface

// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl
// March C- built-in self-test sequencer for a single-port RAM. It drives the
// RAM's addr/data/we directly, checks the RAM's q output, and reports
// pass/fail together with the element, address, expected and actual data of
// the first mismatch. The first mismatch aborts the run.
//
// Ports
//   clk    rising-edge clock, shared with the RAM
//   rst_n  asynchronous, active-low reset
//   bus    march_bist_ctrl_if.master: start, ram_q in; ram_addr, ram_data,
//          ram_we, busy, done, pass, fail_elem/addr/exp/act out
//
// Sequence (10*depth+1 busy cycles in total)
//   M0 up   w0        1 cycle per address
//   M1 up   r0,w1     2 cycles per address (A: read, B: compare + write)
//   M2 up   r1,w0
//   M3 down r0,w1
//   M4 down r1,w0
//   M5 up   r0        pipelined 1 cycle per address, plus one compare-only cycle
module march_bist_ctrl #(
    parameter int addr_width = 6,
    parameter int data_width = 8,
    parameter int depth      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    march_bist_ctrl_if.master   bus
);

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;

    localparam logic [addr_width-1:0] last_addr = addr_width'(depth - 1);

    state_t                state, next_state, succ;
    logic [addr_width-1:0] addr, next_addr;
    logic                  phase, next_phase;

    logic [addr_width-1:0] ram_addr_c, cmp_addr;
    logic [data_width-1:0] ram_data_c, exp_word;
    logic                  ram_we_c, check, mismatch, up_dir, read_ones;
    logic [2:0]            elem_num;

    logic                  pass_r;
    logic [2:0]            fail_elem_r;
    logic [addr_width-1:0] fail_addr_r;
    logic [data_width-1:0] fail_exp_r, fail_act_r;

    // State register: current march element, current address and the
    // sub-cycle flag. In M1..M4 phase selects cycle A (read) or B (compare +
    // write); in M5 phase marks the trailing compare-only cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr  <= '0;
            phase <= 1'b0;
        end else begin
            state <= next_state;
            addr  <= next_addr;
            phase <= next_phase;
        end
    end

    // Next-state and RAM-side outputs. The RAM only latches addr when we=0, so
    // a read issued in one cycle is compared in the following one; in M5 the
    // word compared therefore belongs to the previous address.
    always_comb begin
        next_state = state;
        next_addr  = addr;
        next_phase = phase;
        ram_addr_c = addr;
        ram_data_c = '0;
        ram_we_c   = 1'b0;
        exp_word   = '0;
        check      = 1'b0;
        cmp_addr   = addr;
        elem_num   = 3'd0;
        up_dir     = 1'b1;
        read_ones  = 1'b0;
        succ       = DONE;

        case (state)
            IDLE, DONE: begin
                ram_addr_c = '0;
                if (bus.start) begin
                    next_state = M0;
                    next_addr  = '0;
                    next_phase = 1'b0;
                end
            end
            M0: begin
                ram_we_c = 1'b1;
                if (addr == last_addr) begin
                    next_state = M1;
                    next_addr  = '0;
                end else begin
                    next_addr = addr + 1'b1;
                end
            end
            M1, M2, M3, M4: begin
                up_dir     = (state == M1) || (state == M2);
                read_ones  = (state == M2) || (state == M4);
                exp_word   = read_ones ? '1 : '0;
                ram_data_c = ~exp_word;
                ram_we_c   = phase;
                check      = phase;
                elem_num   = (state == M1) ? 3'd1 : (state == M2) ? 3'd2 :
                             (state == M3) ? 3'd3 : 3'd4;
                succ       = (state == M1) ? M2 : (state == M2) ? M3 :
                             (state == M3) ? M4 : M5;
                if (!phase) begin
                    next_phase = 1'b1;
                end else begin
                    next_phase = 1'b0;
                    if (up_dir ? (addr == last_addr) : (addr == '0)) begin
                        next_state = succ;
                        // M3 and M4 run downwards, so they start at the top.
                        next_addr  = (succ == M3 || succ == M4) ? last_addr : '0;
                    end else begin
                        next_addr = up_dir ? addr + 1'b1 : addr - 1'b1;
                    end
                end
            end
            M5: begin
                elem_num = 3'd5;
                check    = phase || (addr != '0);
                cmp_addr = phase ? addr : addr - 1'b1;
                if (phase) begin
                    next_state = DONE;
                end else if (addr == last_addr) begin
                    next_phase = 1'b1;
                end else begin
                    next_addr = addr + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        mismatch = check && (bus.ram_q != exp_word);
        if (mismatch) begin
            next_state = DONE;
        end
    end

    // Result registers: cleared when a run is accepted, loaded with the first
    // mismatch (which also ends the run), and pass set only when M5's final
    // compare completes cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r      <= 1'b0;
            fail_elem_r <= '0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_act_r  <= '0;
        end else if ((state == IDLE || state == DONE) && bus.start) begin
            pass_r      <= 1'b0;
            fail_elem_r <= '0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_act_r  <= '0;
        end else if (mismatch) begin
            pass_r      <= 1'b0;
            fail_elem_r <= elem_num;
            fail_addr_r <= cmp_addr;
            fail_exp_r  <= exp_word;
            fail_act_r  <= bus.ram_q;
        end else if (state == M5 && phase) begin
            pass_r <= 1'b1;
        end
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_data  = ram_data_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_r;
    assign bus.fail_elem = fail_elem_r;
    assign bus.fail_addr = fail_addr_r;
    assign bus.fail_exp  = fail_exp_r;
    assign bus.fail_act  = fail_act_r;

endmodule
